// File: rtl/lab7_soc_sysid_pkg.sv
// -----------------------------------------------------------------------------
// lab7_soc_sysid_pkg
// Shared types and constants for the lab7_soc system-ID checker.
//   sysid_state_e             : checker FSM states
//   SYSID_ADDR_ID / _TS       : word addresses of the ID and timestamp words
//   SYSID_DEFAULT_EXPECTED_*  : default expected contents of the responder
//   sysid_word_match()        : full 32-bit comparison helper
// -----------------------------------------------------------------------------
package lab7_soc_sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ID   = 3'd1,
    ST_RD_TS   = 3'd2,
    ST_BACKOFF = 3'd3,
    ST_DONE    = 3'd4
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_DEFAULT_EXPECTED_ID = 32'd0;
  localparam logic [31:0] SYSID_DEFAULT_EXPECTED_TS = 32'd1520443765;

  // Full-width equality; a partial match must never count as ok.
  function automatic logic sysid_word_match(input logic [31:0] observed,
                                            input logic [31:0] expected);
    return (observed == expected);
  endfunction

endpackage

// File: rtl/lab7_soc_sysid_wait_timer.sv
// -----------------------------------------------------------------------------
// lab7_soc_sysid_wait_timer
// Wait-state and retry counting for one read word of the system-ID checker.
// Only instantiated when SYSID_CHECK_TIMEOUT_EN is defined.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   clear          : clear both counters (new word / idle)
//   stall          : read outstanding and slave asserting waitrequest
//   expire         : this stall cycle is the last allowed for the attempt
//   give_up        : retry count has reached MAX_RETRIES
// -----------------------------------------------------------------------------
module lab7_soc_sysid_wait_timer
  import lab7_soc_sysid_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRIES    = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic stall,
  output logic expire,
  output logic give_up
);

  localparam logic [15:0] WAIT_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRIES);

  logic [15:0] wait_cnt_r;
  logic [3:0]  retry_cnt_r;
  logic        expire_s;

  assign expire_s = stall && (wait_cnt_r == WAIT_LAST);
  assign expire   = expire_s;
  assign give_up  = (retry_cnt_r == RETRY_LIMIT);

  // Wait counter restarts on every timeout; retry counter saturates at the limit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_r  <= 16'd0;
      retry_cnt_r <= 4'd0;
    end else if (clear) begin
      wait_cnt_r  <= 16'd0;
      retry_cnt_r <= 4'd0;
    end else if (expire_s) begin
      wait_cnt_r  <= 16'd0;
      if (retry_cnt_r != RETRY_LIMIT) begin
        retry_cnt_r <= retry_cnt_r + 4'd1;
      end else begin
        retry_cnt_r <= retry_cnt_r;
      end
    end else if (stall) begin
      wait_cnt_r  <= wait_cnt_r + 16'd1;
    end else begin
      wait_cnt_r  <= wait_cnt_r;
    end
  end

endmodule

// File: rtl/lab7_soc_sysid_checker.sv
// -----------------------------------------------------------------------------
// lab7_soc_sysid_checker
// Avalon-MM master that reads the system ID responder (word 0 = ID,
// word 1 = timestamp) after reset or on request and compares both words with
// EXPECTED_ID / EXPECTED_TS. Status drives an LED and is software readable.
// Optional feature macro: SYSID_CHECK_TIMEOUT_EN (per-attempt wait timeout,
// BACKOFF state and retry limit; without it reads wait indefinitely).
// Ports:
//   clock, reset_n       : clock, asynchronous active-low reset
//   start                : re-run request, honoured only in DONE
//   avm_address/avm_read : Avalon-MM read request (registered)
//   avm_readdata         : read data, valid in accept cycle
//   avm_waitrequest      : slave stall
//   busy, done           : sequencing status
//   id_ok, ts_ok         : comparison results
//   timeout              : check aborted after MAX_RETRIES timeouts
//   id_value, ts_value   : last captured words
// -----------------------------------------------------------------------------
module lab7_soc_sysid_checker
  import lab7_soc_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_EXPECTED_TS,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          MAX_RETRIES    = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  sysid_state_e state_r, state_next_s;

  logic        addr_r, addr_next_s;
  logic        read_r, read_next_s;
  logic        busy_r, busy_next_s;
  logic        done_r, done_next_s;
  logic        id_ok_r, id_ok_next_s;
  logic        ts_ok_r, ts_ok_next_s;
  logic        timeout_r, timeout_next_s;
  logic [31:0] id_value_r, id_value_next_s;
  logic [31:0] ts_value_r, ts_value_next_s;

  logic accept_s;
  logic expire_s;
  logic give_up_s;

  // The registered read strobe is what the slave sees, so accept is judged on it.
  assign accept_s = read_r & ~avm_waitrequest;

`ifdef SYSID_CHECK_TIMEOUT_EN
  logic timer_clear_s;
  logic timer_stall_s;

  // Counters start fresh for each word and whenever no check is running.
  assign timer_clear_s = (state_r == ST_IDLE) | (state_r == ST_DONE) | accept_s;
  assign timer_stall_s = read_r & avm_waitrequest;

  lab7_soc_sysid_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MAX_RETRIES    (MAX_RETRIES)
  ) u_wait_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (timer_clear_s),
    .stall   (timer_stall_s),
    .expire  (expire_s),
    .give_up (give_up_s)
  );
`else
  assign expire_s  = 1'b0;
  assign give_up_s = 1'b0;
`endif

  // Next-state and next-output logic; every output is a register loaded from here.
  always_comb begin
    state_next_s    = state_r;
    addr_next_s     = addr_r;
    read_next_s     = 1'b0;
    busy_next_s     = 1'b1;
    done_next_s     = 1'b0;
    id_ok_next_s    = id_ok_r;
    ts_ok_next_s    = ts_ok_r;
    timeout_next_s  = timeout_r;
    id_value_next_s = id_value_r;
    ts_value_next_s = ts_value_r;

    case (state_r)
      ST_IDLE: begin
        state_next_s = ST_RD_ID;
      end
      ST_RD_ID: begin
        if (accept_s) begin
          state_next_s    = ST_RD_TS;
          id_value_next_s = avm_readdata;
        end else if (expire_s) begin
          state_next_s = ST_BACKOFF;
        end else begin
          state_next_s = ST_RD_ID;
        end
      end
      ST_RD_TS: begin
        if (accept_s) begin
          state_next_s    = ST_DONE;
          ts_value_next_s = avm_readdata;
          // ID was captured on an earlier edge; timestamp compared straight off the bus.
          id_ok_next_s    = sysid_word_match(id_value_r, EXPECTED_ID);
          ts_ok_next_s    = sysid_word_match(avm_readdata, EXPECTED_TS);
          timeout_next_s  = 1'b0;
        end else if (expire_s) begin
          state_next_s = ST_BACKOFF;
        end else begin
          state_next_s = ST_RD_TS;
        end
      end
      ST_BACKOFF: begin
        if (give_up_s) begin
          state_next_s   = ST_DONE;
          id_ok_next_s   = 1'b0;
          ts_ok_next_s   = 1'b0;
          timeout_next_s = 1'b1;
        end else if (addr_r == SYSID_ADDR_TS) begin
          // The held address remembers which word timed out.
          state_next_s = ST_RD_TS;
        end else begin
          state_next_s = ST_RD_ID;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_next_s   = ST_RD_ID;
          id_ok_next_s   = 1'b0;
          ts_ok_next_s   = 1'b0;
          timeout_next_s = 1'b0;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase

    if (state_next_s == ST_RD_ID) begin
      read_next_s = 1'b1;
      addr_next_s = SYSID_ADDR_ID;
    end else if (state_next_s == ST_RD_TS) begin
      read_next_s = 1'b1;
      addr_next_s = SYSID_ADDR_TS;
    end else begin
      read_next_s = 1'b0;
      addr_next_s = addr_r;
    end

    if (state_next_s == ST_DONE) begin
      busy_next_s = 1'b0;
      done_next_s = 1'b1;
    end else begin
      busy_next_s = 1'b1;
      done_next_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered bus and status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_r     <= 1'b0;
      read_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      id_ok_r    <= 1'b0;
      ts_ok_r    <= 1'b0;
      timeout_r  <= 1'b0;
      id_value_r <= 32'd0;
      ts_value_r <= 32'd0;
    end else begin
      addr_r     <= addr_next_s;
      read_r     <= read_next_s;
      busy_r     <= busy_next_s;
      done_r     <= done_next_s;
      id_ok_r    <= id_ok_next_s;
      ts_ok_r    <= ts_ok_next_s;
      timeout_r  <= timeout_next_s;
      id_value_r <= id_value_next_s;
      ts_value_r <= ts_value_next_s;
    end
  end

  assign avm_address = addr_r;
  assign avm_read    = read_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign id_ok       = id_ok_r;
  assign ts_ok       = ts_ok_r;
  assign timeout     = timeout_r;
  assign id_value    = id_value_r;
  assign ts_value    = ts_value_r;

endmodule

// File: tb/tb_lab7_soc_sysid_checker.sv
// -----------------------------------------------------------------------------
// tb_lab7_soc_sysid_checker
// Directed bench for lab7_soc_sysid_checker with a combinational responder
// model (address selects id_resp / ts_resp). Timeout scenario is exercised
// when SYSID_CHECK_TIMEOUT_EN is defined; otherwise indefinite wait is checked.
// -----------------------------------------------------------------------------
module tb_lab7_soc_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1520443765;
  localparam logic [31:0] BAD_TS = 32'h5A9F1234;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  logic [31:0] id_resp;
  logic [31:0] ts_resp;

  int checks = 0;
  int errors = 0;

  lab7_soc_sysid_checker #(
    .EXPECTED_ID    (EXP_ID),
    .EXPECTED_TS    (EXP_TS),
    .TIMEOUT_CYCLES (8),
    .MAX_RETRIES    (3)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .id_ok           (id_ok),
    .ts_ok           (ts_ok),
    .timeout         (timeout),
    .id_value        (id_value),
    .ts_value        (ts_value)
  );

  assign avm_readdata = avm_address ? ts_resp : id_resp;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed,
                     input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset_n         = 1'b0;
    start           = 1'b0;
    avm_waitrequest = 1'b0;
    id_resp         = EXP_ID;
    ts_resp         = EXP_TS;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_read", avm_read, 32'd0);
    chk("rst_addr", avm_address, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_idval", id_value, 32'd0);
    chk("rst_tsval", ts_value, 32'd0);

    // Zero-wait auto-start: E0 RD_ID, E1 accept ID, E2 accept TS
    reset_n = 1'b1;
    tick();
    chk("e0_read", avm_read, 32'd1);
    chk("e0_addr", avm_address, 32'd0);
    chk("e0_busy", busy, 32'd1);
    tick();
    chk("e1_read", avm_read, 32'd1);
    chk("e1_addr", avm_address, 32'd1);
    chk("e1_done", done, 32'd0);
    tick();
    chk("e2_done", done, 32'd1);
    chk("e2_id_ok", id_ok, 32'd1);
    chk("e2_ts_ok", ts_ok, 32'd1);
    chk("e2_timeout", timeout, 32'd0);
    chk("e2_busy", busy, 32'd0);
    chk("e2_read", avm_read, 32'd0);
    chk("e2_tsval", ts_value, EXP_TS);

    // Wrong timestamp
    ts_resp = BAD_TS;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk("bad_read", avm_read, 32'd1);
    chk("bad_done_drop", done, 32'd0);
    tick();
    tick();
    chk("bad_done", done, 32'd1);
    chk("bad_id_ok", id_ok, 32'd1);
    chk("bad_ts_ok", ts_ok, 32'd0);
    chk("bad_tsval", ts_value, BAD_TS);

    // Four waitrequest cycles on the timestamp word
    ts_resp = EXP_TS;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wr_read_hold", avm_read, 32'd1);
      chk("wr_addr_hold", avm_address, 32'd1);
      chk("wr_done", done, 32'd0);
    end
    avm_waitrequest = 1'b0;
    tick();
    chk("wr_done_end", done, 32'd1);
    chk("wr_id_ok", id_ok, 32'd1);
    chk("wr_ts_ok", ts_ok, 32'd1);

    // start during RD_TS is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    avm_waitrequest = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_addr", avm_address, 32'd1);
    chk("ign_read", avm_read, 32'd1);
    chk("ign_busy", busy, 32'd1);
    avm_waitrequest = 1'b0;
    tick();
    chk("ign_done", done, 32'd1);
    chk("ign_ts_ok", ts_ok, 32'd1);

    // Waitrequest stuck high on the ID word
    id_resp         = 32'hDEADBEEF;
    avm_waitrequest = 1'b1;
    start           = 1'b1;
    tick();
    start = 1'b0;
`ifdef SYSID_CHECK_TIMEOUT_EN
    repeat (7) tick();
    chk("to_e7_read", avm_read, 32'd1);
    tick();
    chk("to_backoff_read", avm_read, 32'd0);
    chk("to_backoff_busy", busy, 32'd1);
    tick();
    chk("to_retry_read", avm_read, 32'd1);
    chk("to_retry_addr", avm_address, 32'd0);
    repeat (17) tick();
    chk("to_e26_done", done, 32'd0);
    chk("to_e26_read", avm_read, 32'd0);
    tick();
    chk("to_done", done, 32'd1);
    chk("to_timeout", timeout, 32'd1);
    chk("to_id_ok", id_ok, 32'd0);
    chk("to_ts_ok", ts_ok, 32'd0);
    chk("to_busy", busy, 32'd0);
    chk("to_idval", id_value, 32'd0);
    avm_waitrequest = 1'b0;
    id_resp         = EXP_ID;
`else
    repeat (40) tick();
    chk("stuck_read", avm_read, 32'd1);
    chk("stuck_addr", avm_address, 32'd0);
    chk("stuck_busy", busy, 32'd1);
    chk("stuck_done", done, 32'd0);
    chk("stuck_timeout", timeout, 32'd0);
    avm_waitrequest = 1'b0;
    id_resp         = EXP_ID;
    tick();
    tick();
    chk("stuck_end_done", done, 32'd1);
    chk("stuck_end_id_ok", id_ok, 32'd1);
    chk("stuck_end_timeout", timeout, 32'd0);
`endif

    // Reset while RD_TS stalled
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rr_timeout_clr", timeout, 32'd0);
    chk("rr_done_clr", done, 32'd0);
    tick();
    avm_waitrequest = 1'b1;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rr_read", avm_read, 32'd0);
    chk("rr_addr", avm_address, 32'd0);
    chk("rr_busy", busy, 32'd0);
    chk("rr_done", done, 32'd0);
    chk("rr_id_ok", id_ok, 32'd0);
    chk("rr_tsval", ts_value, 32'd0);
    avm_waitrequest = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("rr_e0_read", avm_read, 32'd1);
    chk("rr_e0_addr", avm_address, 32'd0);
    tick();
    tick();
    chk("rr_e2_done", done, 32'd1);
    chk("rr_e2_id_ok", id_ok, 32'd1);
    chk("rr_e2_ts_ok", ts_ok, 32'd1);
    chk("rr_e2_tsval", ts_value, EXP_TS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
